// File: rtl/serie_paralelo_pkg.sv
// Shared definitions for the paraleloSerial link.
//   COMMA_CHAR : idle/alignment symbol, also emitted by the transmitter when idle.
//   state_e    : receiver alignment state encoding.
package serie_paralelo_pkg;

    localparam logic [7:0] COMMA_CHAR = 8'hBC;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StAlign  = 2'd1,
        StActive = 2'd2
    } state_e;

endpackage

// File: rtl/serie_shift_counter.sv
// Serial-to-parallel front end: bit history plus 3-bit bit counter.
//   clk_32f  : bit-rate clock
//   reset    : asynchronous active-low reset
//   data_in  : serial bit, MSB first
//   realign  : force bit_cnt to 0 on this edge (alignment found)
//   w        : byte completed by the bit sampled this edge
//   boundary : this edge samples the LSB of an aligned byte
module serie_shift_counter (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       realign,
    output logic [7:0] w,
    output logic       boundary
);

    // Only the seven most recent bits are ever read; the eighth is
    // always shifted out before it could contribute to w.
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q;

    assign w        = {sr_q, data_in};
    assign boundary = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr_q      <= 7'd0;
            bit_cnt_q <= 3'd0;
        end else begin
            sr_q      <= w[6:0];
            bit_cnt_q <= realign ? 3'd0 : bit_cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/serie_paralelo.sv
// Receive side of the paraleloSerial link: finds byte alignment on the comma,
// declares the link active after COMMA_COUNT aligned commas, then delivers
// non-comma bytes.
//   clk_32f   : bit-rate clock (only clock)
//   reset     : asynchronous active-low reset
//   data_in   : serial bit, MSB first
//   data_out  : last received non-comma byte
//   valid_out : data_out holds a data byte for the current byte period
//   active    : link aligned and synchronised
module serie_paralelo
    import serie_paralelo_pkg::*;
#(
    parameter logic [7:0]  COMMA       = COMMA_CHAR,
    parameter int unsigned COMMA_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [3:0] CNT_LAST = 4'(COMMA_COUNT - 1);

    state_e     state_q, state_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;
    logic       realign;
    logic [7:0] w;
    logic       boundary;
    logic       is_comma;

    serie_shift_counter u_shift (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .realign  (realign),
        .w        (w),
        .boundary (boundary)
    );

    assign is_comma = (w == COMMA);

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        active_d    = active_q;
        realign     = 1'b0;
        unique case (state_q)
            StHunt: begin
                // Bit-by-bit search; a match defines the byte boundary.
                if (is_comma) begin
                    realign     = 1'b1;
                    comma_cnt_d = 4'd1;
                    if (COMMA_COUNT == 1) begin
                        state_d  = StActive;
                        active_d = 1'b1;
                    end else begin
                        state_d = StAlign;
                    end
                end
            end
            StAlign: begin
                if (boundary) begin
                    if (is_comma) begin
                        if (comma_cnt_q == CNT_LAST) begin
                            state_d  = StActive;
                            active_d = 1'b1;
                        end else begin
                            comma_cnt_d = comma_cnt_q + 4'd1;
                        end
                    end else begin
                        // False lock: drop the byte and search again.
                        state_d     = StHunt;
                        comma_cnt_d = 4'd0;
                    end
                end
            end
            StActive: begin
                if (boundary) begin
                    if (is_comma) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = w;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q     <= StHunt;
            comma_cnt_q <= 4'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serie_paralelo.sv
module tb_serie_paralelo;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_cmp = 0;
    int n_err = 0;

    serie_paralelo dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                             input logic a);
        check({tag, "_data"}, data_out, d);
        check({tag, "_valid"}, {7'd0, valid_out}, {7'd0, v});
        check({tag, "_active"}, {7'd0, active}, {7'd0, a});
    endtask

    // Drive one bit away from the edge, return just after the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Send a byte MSB first; outputs must hold the given values for the first
    // seven bits. The caller checks the result after the LSB.
    task automatic send_byte(input string tag, input logic [7:0] b, input logic [7:0] hd,
                             input logic hv, input logic ha);
        for (int i = 7; i >= 1; i--) begin
            send_bit(b[i]);
            check_out({tag, "_hold"}, hd, hv, ha);
        end
        send_bit(b[0]);
    endtask

    initial begin
        // Reset held for three edges with data toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_32f);
            data_in = ~data_in;
            @(posedge clk_32f);
            #1;
            check_out("reset", 8'h00, 1'b0, 1'b0);
        end
        @(negedge clk_32f);
        reset = 1'b1;

        // Four commas, then FF, EE, idle.
        for (int i = 0; i < 3; i++) begin
            send_byte("comma_a", 8'hBC, 8'h00, 1'b0, 1'b0);
            check_out("align_a", 8'h00, 1'b0, 1'b0);
        end
        send_byte("comma_a4", 8'hBC, 8'h00, 1'b0, 1'b0);
        check_out("active_rise", 8'h00, 1'b0, 1'b1);
        send_byte("ff", 8'hFF, 8'h00, 1'b0, 1'b1);
        check_out("ff", 8'hFF, 1'b1, 1'b1);
        send_byte("ee", 8'hEE, 8'hFF, 1'b1, 1'b1);
        check_out("ee", 8'hEE, 1'b1, 1'b1);
        send_byte("idle", 8'hBC, 8'hEE, 1'b1, 1'b1);
        check_out("idle", 8'hEE, 1'b0, 1'b1);

        // Data, comma, data while active.
        send_byte("b33", 8'h33, 8'hEE, 1'b0, 1'b1);
        check_out("b33", 8'h33, 1'b1, 1'b1);
        send_byte("mid_comma", 8'hBC, 8'h33, 1'b1, 1'b1);
        check_out("mid_comma", 8'h33, 1'b0, 1'b1);
        send_byte("b44", 8'h44, 8'h33, 1'b0, 1'b1);
        check_out("b44", 8'h44, 1'b1, 1'b1);

        // Asynchronous reset mid-byte.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_out("pre_rst", 8'h44, 1'b1, 1'b1);
        #2 reset = 1'b0;
        #1 check_out("async_rst", 8'h00, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk_32f);
            #1;
            check_out("rst_hold", 8'h00, 1'b0, 1'b0);
        end
        @(negedge clk_32f);
        reset = 1'b1;

        // Junk bits, then alignment found mid-stream.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_out("junk", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte("comma_b", 8'hBC, 8'h00, 1'b0, 1'b0);
            check_out("align_b", 8'h00, 1'b0, 1'b0);
        end
        send_byte("comma_b4", 8'hBC, 8'h00, 1'b0, 1'b0);
        check_out("active_b", 8'h00, 1'b0, 1'b1);
        send_byte("b5a", 8'h5A, 8'h00, 1'b0, 1'b1);
        check_out("b5a", 8'h5A, 1'b1, 1'b1);

        // Plain reset, then a broken alignment run.
        @(negedge clk_32f);
        reset = 1'b0;
        #1 check_out("rst2", 8'h00, 1'b0, 1'b0);
        @(negedge clk_32f);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte("comma_c", 8'hBC, 8'h00, 1'b0, 1'b0);
            check_out("align_c", 8'h00, 1'b0, 1'b0);
        end
        send_byte("b11", 8'h11, 8'h00, 1'b0, 1'b0);
        check_out("b11_drop", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte("comma_d", 8'hBC, 8'h00, 1'b0, 1'b0);
            check_out("align_d", 8'h00, 1'b0, 1'b0);
        end
        send_byte("comma_d4", 8'hBC, 8'h00, 1'b0, 1'b0);
        check_out("active_d", 8'h00, 1'b0, 1'b1);
        send_byte("b22", 8'h22, 8'h00, 1'b0, 1'b1);
        check_out("b22", 8'h22, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
